sobel_line_fifo: RTL and testbench
==================================

# sobel_line_fifo

Parametrised multi-tap delay line for the Sobel window datapath. It generalises the fixed 8-cell, 8-bit enable-gated FIFO to configurable data width, per-tap depth and tap count. It adds reset, flush, fill tracking and a primed flag. It sits between the pixel stream source and the 3x3 window register bank, supplying the delayed rows (one tap per previous image line).

## Interface
Parameters:
- DATA_W, 8, bits per sample
- DEPTH, 8, delay per tap in accepted samples (line length); DEPTH >= 2
- TAPS, 2, number of cascaded delay stages; TAPS >= 1

Ports:
- CLK  input  1  single clock, rising-edge
- RST  input  1  asynchronous, active-high reset
- Enable  input  1  accept DataIn and advance all taps this cycle
- Flush  input  1  synchronous clear of fill state and pointers
- DataIn  input  DATA_W  incoming sample
- DataOut  output  TAPS*DATA_W  tap k in bits [(k+1)*DATA_W-1 : k*DATA_W]
- TapValid  output  TAPS  bit k high when tap k holds real data
- Valid  output  1  all taps primed (equals TapValid[TAPS-1])
- FillCount  output  clog2(TAPS*DEPTH+1)  accepted samples since reset/flush, saturating

## Operation
- Reference model: a shift register of TAPS*DEPTH stages advanced only on Enable. Stage 0 is the newest sample.
- Tap k = stage (k+1)*DEPTH-1, so it is DataIn delayed by (k+1)*DEPTH accepted samples.
- Enable=0: all state and outputs hold; bubbles never advance data.
- FillCount increments on each Enable and saturates at TAPS*DEPTH.
- TapValid[k] = (FillCount >= (k+1)*DEPTH).
- Flush=1 on an edge:
  - FillCount, TapValid and Valid go to 0; pointers go to 0.
  - Flush has priority over a simultaneous Enable; that cycle's DataIn is discarded.
- Each tap is a ring buffer of DEPTH-1 entries with a read-before-write pointer, plus a DATA_W output register.
  - Pointer wraps from DEPTH-2 to 0.
  - The output register of tap k feeds DataIn of tap k+1.
- Reset values: DataOut all 0, TapValid 0, Valid 0, FillCount 0, pointers 0. Ring storage is not reset.
- RST asserted mid-stream: all outputs immediately (asynchronously) go to the reset values. Streaming restarts from empty after RST deasserts.

## Timing
- Latency: DataOut tap k reflects the sample accepted (k+1)*DEPTH Enable-edges earlier. It updates on the same rising edge that accepts the new sample.
- With DEPTH=8, TAPS=2:
  - TapValid[0] rises at the edge of the 8th accepted sample.
  - Valid rises at the edge of the 16th accepted sample.
- FillCount, TapValid and Valid are registered and change only on CLK edges (except asynchronous RST).
- No ready/backpressure: the block always accepts when Enable=1.
- Wrap-around: continuous Enable for more than TAPS*DEPTH cycles keeps FillCount saturated and Valid high. Delay stays exact across pointer wrap.

## Configuration
- SOBEL_FIFO_ZEROFILL_EN defined:
  - Tap k output is forced to 0 while TapValid[k]=0, including after Flush.
  - Stale ring contents are never visible.
- Not defined:
  - Raw tap registers are driven out.
  - After Flush, DataOut may show stale pre-flush samples until each tap re-primes. Consumers must qualify with TapValid.
- Behaviour is identical in both modes once a tap is primed.

## Structure
- Package sobel_fifo_pkg holds:
  - Default DATA_W/DEPTH/TAPS constants.
  - The count-width function clog2(TAPS*DEPTH+1).
  - A pixel_t typedef of DATA_W bits.
- One sub-module, sobel_tap_delay: a single DEPTH-sample ring-buffer stage with an output register. The top instantiates TAPS of them in a generate chain.
- Top-level logic covers FillCount, TapValid/Valid, Flush fan-out and zero-fill gating.

## Test plan
All scenarios use DATA_W=8, DEPTH=8, TAPS=2, 30 ns clock.
- Ramp fill: RST pulse, then Enable=1 with DataIn=1,2,3,… →
  - TapValid[0] rises on the sample-8 edge with tap0=1.
  - Valid rises on the sample-16 edge with tap1=1 and tap0=9.
  - FillCount saturates at 16.
- Enable gating: toggle Enable every 400 ns with random DataIn, as in the existing fast-FIFO bench → outputs hold while Enable=0. Tap delays measured in accepted samples match the shift-register model exactly.
- Flush collision: stream 20 samples, then assert Flush and Enable together with DataIn=0xAA →
  - Next edge: FillCount=0, Valid=0.
  - 0xAA never appears on any tap.
  - With SOBEL_FIFO_ZEROFILL_EN, DataOut=0 until re-primed.
- Async reset mid-stream: assert RST between edges after 12 samples → DataOut, FillCount and TapValid are 0 before the next edge. Refill after release behaves like the ramp-fill scenario.
- Long run wrap: 1000 random samples with continuous Enable → tap1 equals DataIn from 16 accepts earlier on every edge, with no glitch at pointer wrap.
- Parameter sweep: DEPTH=2, TAPS=3, DATA_W=12 → tap k delay equals 2*(k+1) accepted samples, and Valid rises on the 6th accept.

Source files
------------

// File: rtl/sobel_line_fifo_pkg.sv
// Shared constants and helpers for the Sobel line delay FIFO.
// Holds the default geometry, the fill-counter width function and the
// default pixel type used by the window datapath.
package sobel_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_TAPS   = 2;

  typedef logic [DEF_DATA_W-1:0] pixel_t;

  // Width needed to count 0 .. taps*depth inclusive.
  function automatic int cnt_w(input int taps, input int depth);
    return $clog2(taps * depth + 1);
  endfunction

endpackage

// File: rtl/sobel_line_fifo_if.sv
// Stream-side bundle of the Sobel line delay FIFO.
// slave: the FIFO itself; master: the pixel source / window bank side.
interface sobel_line_fifo_if
  import sobel_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TAPS   = DEF_TAPS
);

  localparam int CNT_W = cnt_w(TAPS, DEPTH);

  logic                     Enable;
  logic                     Flush;
  logic [DATA_W-1:0]        DataIn;
  logic [TAPS*DATA_W-1:0]   DataOut;
  logic [TAPS-1:0]          TapValid;
  logic                     Valid;
  logic [CNT_W-1:0]         FillCount;

  modport slave (
    input  Enable,
    input  Flush,
    input  DataIn,
    output DataOut,
    output TapValid,
    output Valid,
    output FillCount
  );

  modport master (
    output Enable,
    output Flush,
    output DataIn,
    input  DataOut,
    input  TapValid,
    input  Valid,
    input  FillCount
  );

endinterface

// File: rtl/sobel_line_fifo_tap_delay.sv
// One delay stage of the line FIFO: a ring of DEPTH-1 entries read before
// write, followed by an output register, giving DEPTH accepted samples of
// delay. Ring storage is deliberately not reset; only the pointer and the
// output register are.
module sobel_tap_delay
  import sobel_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Enable,
  input  logic              Flush,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut
);

  logic [DATA_W-1:0] out_q;

  generate
    if (DEPTH == 2) begin : g_single
      logic [DATA_W-1:0] hold_q;
      // A one-entry ring has no pointer, so Flush has nothing to clear here.
      logic              flush_unused;
      assign flush_unused = Flush;

      // Single ring slot: captures the incoming sample on each accept.
      always_ff @(posedge CLK) begin
        if (Enable) hold_q <= DataIn;
      end

      // Output register: takes the slot contents before they are overwritten.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)         out_q <= '0;
        else if (Enable) out_q <= hold_q;
      end
    end else begin : g_ring
      localparam int                 PTR_W    = $clog2(DEPTH - 1);
      localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 2);

      logic [DATA_W-1:0] ring [DEPTH-1];
      logic [PTR_W-1:0]  ptr_q;

      // Ring pointer: advances per accept, wraps DEPTH-2 -> 0, cleared by Flush.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)        ptr_q <= '0;
        else if (Flush) ptr_q <= '0;
        else if (Enable) begin
          if (ptr_q == PTR_LAST) ptr_q <= '0;
          else                   ptr_q <= ptr_q + 1'b1;
        end
      end

      // Ring storage: write the new sample into the slot just read out.
      always_ff @(posedge CLK) begin
        if (Enable && !Flush) ring[ptr_q] <= DataIn;
      end

      // Output register: oldest ring entry, read before it is overwritten.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST)                   out_q <= '0;
        else if (Enable && !Flush) out_q <= ring[ptr_q];
      end
    end
  endgenerate

  assign DataOut = out_q;

endmodule

// File: rtl/sobel_line_fifo.sv
// Multi-tap line delay for the Sobel 3x3 window: TAPS cascaded stages of
// DEPTH samples each, one tap per previous image line.
// Optional build macro: SOBEL_FIFO_ZEROFILL_EN -- when defined, a tap reads
// as zero until it is primed, so stale ring contents never leak out.
// Without it the raw tap registers are driven and consumers must qualify
// each tap with TapValid.
module sobel_line_fifo
  import sobel_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,   // must be >= 2
  parameter int TAPS   = DEF_TAPS     // must be >= 1
) (
  input  logic              CLK,
  input  logic              RST,
  sobel_line_fifo_if.slave  bus
);

  localparam int               CNT_W    = cnt_w(TAPS, DEPTH);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(TAPS * DEPTH);

  // Flush wins over a coincident Enable: that cycle's sample is dropped.
  logic             adv;
  logic [CNT_W-1:0] fill_q;
  logic [TAPS-1:0]  tap_valid;

  logic [DATA_W-1:0] tap_in  [TAPS];
  logic [DATA_W-1:0] tap_out [TAPS];

  assign adv = bus.Enable & ~bus.Flush;

  // Accepted-sample counter since reset/flush, saturating at full depth.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                         fill_q <= '0;
    else if (bus.Flush)              fill_q <= '0;
    else if (adv && fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
  end

  generate
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
      if (k == 0) begin : g_head
        assign tap_in[k] = bus.DataIn;
      end else begin : g_link
        assign tap_in[k] = tap_out[k-1];
      end

      sobel_tap_delay #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
      ) u_tap (
        .CLK     (CLK),
        .RST     (RST),
        .Enable  (adv),
        .Flush   (bus.Flush),
        .DataIn  (tap_in[k]),
        .DataOut (tap_out[k])
      );

      // Tap k is primed once (k+1)*DEPTH samples have been accepted.
      assign tap_valid[k] = (fill_q >= CNT_W'((k + 1) * DEPTH));

`ifdef SOBEL_FIFO_ZEROFILL_EN
      assign bus.DataOut[k*DATA_W +: DATA_W] = tap_valid[k] ? tap_out[k] : '0;
`else
      assign bus.DataOut[k*DATA_W +: DATA_W] = tap_out[k];
`endif
    end
  endgenerate

  assign bus.TapValid  = tap_valid;
  assign bus.Valid     = tap_valid[TAPS-1];
  assign bus.FillCount = fill_q;

endmodule

// File: tb/tb_sobel_line_fifo.sv
// Self-checking bench for sobel_line_fifo. Instance A uses the default
// geometry (8b, DEPTH 8, TAPS 2); instance B is the small sweep geometry
// (12b, DEPTH 2, TAPS 3). Expected values come from a history of accepted
// samples: tap k equals the sample accepted (k+1)*DEPTH accepts ago.
module tb_sobel_line_fifo;
  import sobel_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #15 clk = ~clk;

  int total  = 0;
  int passed = 0;

  sobel_line_fifo_if #(.DATA_W(8),  .DEPTH(8), .TAPS(2)) bus_a ();
  sobel_line_fifo_if #(.DATA_W(12), .DEPTH(2), .TAPS(3)) bus_b ();

  sobel_line_fifo #(.DATA_W(8),  .DEPTH(8), .TAPS(2)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
  sobel_line_fifo #(.DATA_W(12), .DEPTH(2), .TAPS(3)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  logic [7:0]  hist_a [$];
  logic [11:0] hist_b [$];

  // ---------------- reference model ----------------
  function automatic logic [15:0] exp_out_a();
    logic [15:0] e = '0;
    int n = hist_a.size();
    for (int k = 0; k < 2; k++)
      if (n >= (k + 1) * 8) e[k*8 +: 8] = hist_a[n - (k + 1) * 8];
    return e;
  endfunction

  function automatic logic [15:0] mask_a();
    logic [15:0] m = '0;
    int n = hist_a.size();
`ifdef SOBEL_FIFO_ZEROFILL_EN
    m = '1;
`else
    for (int k = 0; k < 2; k++)
      if (n >= (k + 1) * 8) m[k*8 +: 8] = '1;
`endif
    return m;
  endfunction

  function automatic logic [1:0] exp_tv_a();
    logic [1:0] t = '0;
    for (int k = 0; k < 2; k++) t[k] = (hist_a.size() >= (k + 1) * 8);
    return t;
  endfunction

  function automatic logic [4:0] exp_fill_a();
    return 5'((hist_a.size() > 16) ? 16 : hist_a.size());
  endfunction

  function automatic logic [35:0] exp_out_b();
    logic [35:0] e = '0;
    int n = hist_b.size();
    for (int k = 0; k < 3; k++)
      if (n >= (k + 1) * 2) e[k*12 +: 12] = hist_b[n - (k + 1) * 2];
    return e;
  endfunction

  function automatic logic [35:0] mask_b();
    logic [35:0] m = '0;
    int n = hist_b.size();
`ifdef SOBEL_FIFO_ZEROFILL_EN
    m = '1;
`else
    for (int k = 0; k < 3; k++)
      if (n >= (k + 1) * 2) m[k*12 +: 12] = '1;
`endif
    return m;
  endfunction

  function automatic logic [2:0] exp_tv_b();
    logic [2:0] t = '0;
    for (int k = 0; k < 3; k++) t[k] = (hist_b.size() >= (k + 1) * 2);
    return t;
  endfunction

  function automatic logic [2:0] exp_fill_b();
    return 3'((hist_b.size() > 6) ? 6 : hist_b.size());
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_all();
    bus_a.Enable = 1'b0; bus_a.Flush = 1'b0; bus_a.DataIn = '0;
    bus_b.Enable = 1'b0; bus_b.Flush = 1'b0; bus_b.DataIn = '0;
  endtask

  task automatic pulse_reset();
    idle_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    hist_a.delete();
    hist_b.delete();
    #10;
    rst = 1'b0;
  endtask

  task automatic step_a(input logic en, input logic fl, input logic [7:0] d);
    bus_a.Enable = en; bus_a.Flush = fl; bus_a.DataIn = d;
    @(posedge clk);
    if (fl)      hist_a.delete();
    else if (en) hist_a.push_back(d);
    #1;
  endtask

  task automatic step_b(input logic en, input logic [11:0] d);
    bus_b.Enable = en; bus_b.Flush = 1'b0; bus_b.DataIn = d;
    @(posedge clk);
    if (en) hist_b.push_back(d);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_all();
    #2;
    rst = 1'b1;
    #5;
    total++; if (bus_a.DataOut !== 16'h0) $display("FAIL reset_dataout_a got %h want 0", bus_a.DataOut); else passed++;
    total++; if (bus_a.TapValid !== 2'b00) $display("FAIL reset_tapvalid_a got %b want 00", bus_a.TapValid); else passed++;
    total++; if (bus_a.Valid !== 1'b0) $display("FAIL reset_valid_a got %b want 0", bus_a.Valid); else passed++;
    total++; if (bus_a.FillCount !== 5'd0) $display("FAIL reset_fill_a got %0d want 0", bus_a.FillCount); else passed++;
    total++; if (bus_b.DataOut !== 36'h0) $display("FAIL reset_dataout_b got %h want 0", bus_b.DataOut); else passed++;
    total++; if (bus_b.FillCount !== 3'd0) $display("FAIL reset_fill_b got %0d want 0", bus_b.FillCount); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_ramp_fill(input bit do_reset);
    if (do_reset) pulse_reset();
    for (int i = 1; i <= 20; i++) begin
      step_a(1'b1, 1'b0, 8'(i));
      total++;
      if ((bus_a.DataOut & mask_a()) !== (exp_out_a() & mask_a()))
        $display("FAIL ramp_data step %0d got %h want %h", i, bus_a.DataOut & mask_a(), exp_out_a() & mask_a());
      else passed++;
      total++;
      if (bus_a.FillCount !== exp_fill_a() || bus_a.TapValid !== exp_tv_a())
        $display("FAIL ramp_fill step %0d got fill %0d tv %b want fill %0d tv %b",
                 i, bus_a.FillCount, bus_a.TapValid, exp_fill_a(), exp_tv_a());
      else passed++;
      if (i == 7) begin
        total++; if (bus_a.TapValid[0] !== 1'b0) $display("FAIL ramp_tv0_early got %b want 0", bus_a.TapValid[0]); else passed++;
      end
      if (i == 8) begin
        total++;
        if (bus_a.TapValid[0] !== 1'b1 || bus_a.DataOut[7:0] !== 8'd1)
          $display("FAIL ramp_tap0_prime got tv %b tap0 %0d want tv 1 tap0 1", bus_a.TapValid[0], bus_a.DataOut[7:0]);
        else passed++;
      end
      if (i == 15) begin
        total++; if (bus_a.Valid !== 1'b0) $display("FAIL ramp_valid_early got %b want 0", bus_a.Valid); else passed++;
      end
      if (i == 16) begin
        total++;
        if (bus_a.Valid !== 1'b1 || bus_a.DataOut[15:8] !== 8'd1 || bus_a.DataOut[7:0] !== 8'd9)
          $display("FAIL ramp_valid_prime got valid %b tap1 %0d tap0 %0d want 1 1 9",
                   bus_a.Valid, bus_a.DataOut[15:8], bus_a.DataOut[7:0]);
        else passed++;
      end
    end
    total++; if (bus_a.FillCount !== 5'd16) $display("FAIL ramp_saturate got %0d want 16", bus_a.FillCount); else passed++;
  endtask

  task automatic test_enable_gating();
    pulse_reset();
    for (int cyc = 0; cyc < 160; cyc++) begin
      logic en;
      en = (((cyc * 30) / 400) % 2) == 0;
      step_a(en, 1'b0, 8'($urandom));
      total++;
      if ((bus_a.DataOut & mask_a()) !== (exp_out_a() & mask_a()) ||
          bus_a.FillCount !== exp_fill_a() || bus_a.TapValid !== exp_tv_a())
        $display("FAIL gating cyc %0d got data %h fill %0d tv %b want data %h fill %0d tv %b",
                 cyc, bus_a.DataOut & mask_a(), bus_a.FillCount, bus_a.TapValid,
                 exp_out_a() & mask_a(), exp_fill_a(), exp_tv_a());
      else passed++;
    end
  endtask

  task automatic test_flush_collision();
    pulse_reset();
    for (int i = 1; i <= 20; i++) step_a(1'b1, 1'b0, 8'(i));
    step_a(1'b1, 1'b1, 8'hAA);
    total++; if (bus_a.FillCount !== 5'd0) $display("FAIL flush_fill got %0d want 0", bus_a.FillCount); else passed++;
    total++; if (bus_a.Valid !== 1'b0 || bus_a.TapValid !== 2'b00)
      $display("FAIL flush_valid got valid %b tv %b want 0 00", bus_a.Valid, bus_a.TapValid); else passed++;
`ifdef SOBEL_FIFO_ZEROFILL_EN
    total++; if (bus_a.DataOut !== 16'h0) $display("FAIL flush_zerofill got %h want 0", bus_a.DataOut); else passed++;
`endif
    for (int i = 1; i <= 20; i++) begin
      step_a(1'b1, 1'b0, 8'(100 + i));
      total++;
      if (bus_a.DataOut[7:0] === 8'hAA || bus_a.DataOut[15:8] === 8'hAA)
        $display("FAIL flush_leak step %0d got %h want no AA", i, bus_a.DataOut);
      else passed++;
      total++;
      if ((bus_a.DataOut & mask_a()) !== (exp_out_a() & mask_a()) ||
          bus_a.FillCount !== exp_fill_a() || bus_a.TapValid !== exp_tv_a())
        $display("FAIL flush_refill step %0d got data %h fill %0d tv %b want data %h fill %0d tv %b",
                 i, bus_a.DataOut & mask_a(), bus_a.FillCount, bus_a.TapValid,
                 exp_out_a() & mask_a(), exp_fill_a(), exp_tv_a());
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    for (int i = 0; i < 12; i++) step_a(1'b1, 1'b0, 8'($urandom));
    idle_all();
    #9;
    rst = 1'b1;
    hist_a.delete();
    hist_b.delete();
    #1;
    total++; if (bus_a.DataOut !== 16'h0) $display("FAIL async_dataout got %h want 0", bus_a.DataOut); else passed++;
    total++; if (bus_a.FillCount !== 5'd0 || bus_a.TapValid !== 2'b00)
      $display("FAIL async_fill got fill %0d tv %b want 0 00", bus_a.FillCount, bus_a.TapValid); else passed++;
    #5;
    rst = 1'b0;
    test_ramp_fill(1'b0);
  endtask

  task automatic test_long_run();
    pulse_reset();
    for (int i = 0; i < 1000; i++) begin
      step_a(1'b1, 1'b0, 8'($urandom));
      if (hist_a.size() >= 16) begin
        total++;
        if (bus_a.DataOut[15:8] !== hist_a[hist_a.size() - 16] || bus_a.Valid !== 1'b1)
          $display("FAIL long_tap1 accept %0d got tap1 %h valid %b want %h 1",
                   hist_a.size(), bus_a.DataOut[15:8], bus_a.Valid, hist_a[hist_a.size() - 16]);
        else passed++;
      end
    end
    total++; if (bus_a.FillCount !== 5'd16) $display("FAIL long_saturate got %0d want 16", bus_a.FillCount); else passed++;
  endtask

  task automatic test_param_sweep();
    int first_valid = -1;
    pulse_reset();
    for (int i = 0; i < 40; i++) begin
      step_b($urandom_range(0, 3) != 0, 12'($urandom));
      if (first_valid < 0 && bus_b.Valid === 1'b1) first_valid = hist_b.size();
      total++;
      if ((bus_b.DataOut & mask_b()) !== (exp_out_b() & mask_b()) ||
          bus_b.FillCount !== exp_fill_b() || bus_b.TapValid !== exp_tv_b())
        $display("FAIL sweep cyc %0d got data %h fill %0d tv %b want data %h fill %0d tv %b",
                 i, bus_b.DataOut & mask_b(), bus_b.FillCount, bus_b.TapValid,
                 exp_out_b() & mask_b(), exp_fill_b(), exp_tv_b());
      else passed++;
    end
    total++; if (first_valid != 6) $display("FAIL sweep_valid_rise got accept %0d want 6", first_valid); else passed++;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_ramp_fill(1'b1);
    test_enable_gating();
    test_flush_collision();
    test_async_reset();
    test_long_run();
    test_param_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
